bai_tap_2_sequence_generator: RTL and testbench
===============================================

BAI_TAP_2_SEQUENCE_GENERATOR -- requirements
Module: bai_tap_2_sequence_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning maximum pattern length in bits.
REQ-002 SHALL have parameter LW, default 4, meaning width of the len port (holds 0..WIDTH).
REQ-003 SHALL have parameter RW, default 4, meaning width of the rep port.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request to begin transmission, sampled on rising clk.
REQ-007 SHALL have port stop  input  1  request to end continuous/repeated transmission gracefully.
REQ-008 SHALL have port pattern  input  WIDTH  bit pattern; bits [len-1:0] are sent MSB-first.
REQ-009 SHALL have port len  input  LW  number of pattern bits to send.
REQ-010 SHALL have port rep  input  RW  number of pattern transmissions; 0 = continuous.
REQ-011 SHALL have port w  output  1  serial bit stream, registered (feeds a sequence detector's w input).
REQ-012 SHALL have port valid  output  1  high while w carries a pattern bit, registered.
REQ-013 SHALL have port busy  output  1  high from the first SEND cycle through the DONE cycle, registered.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse, registered.

Function
REQ-015 SHALL implement FSM with states IDLE, SEND, DONE.
REQ-016 In IDLE, w=0, valid=0, busy=0, done=0.
REQ-017 In IDLE with start=1 at a rising edge, SHALL latch pattern, len, rep, and enter SEND; the first bit appears on w in the next cycle (latency 1).
REQ-018 Latched len of 0 or greater than WIDTH SHALL be treated as WIDTH.
REQ-019 In SEND, each cycle w=pattern_latched[idx], valid=1, busy=1; idx starts at len-1 and decrements by 1 per cycle.
REQ-020 At idx==0 with remaining repetitions > 1 (or rep==0 and no pending stop), idx SHALL reload to len-1 with no gap cycle (back-to-back).
REQ-021 At idx==0 on the final repetition, the next state SHALL be DONE.
REQ-022 Remaining-repetition counter SHALL decrement once per completed pattern; rep==0 SHALL never decrement or terminate without stop.
REQ-023 stop=1 in SEND SHALL be latched as pending; the current pattern completes, then DONE is entered (no truncated pattern).
REQ-024 stop in IDLE or DONE SHALL be ignored and SHALL NOT remain pending.
REQ-025 DONE lasts exactly one cycle: done=1, busy=1, w=0, valid=0; then IDLE.
REQ-026 start while busy=1 (SEND or DONE) SHALL be ignored; no re-latch of inputs.
REQ-027 start and stop both high in IDLE: start SHALL be honoured, stop ignored.
REQ-028 Changes on pattern/len/rep after the start edge SHALL NOT affect the transmission in progress.

Reset
REQ-029 reset=1 SHALL immediately, without a clock edge, force state IDLE, w=0, valid=0, busy=0, done=0, idx=0, counters=0, stop-pending=0.
REQ-030 Reset asserted mid-SEND SHALL abort transmission with no done pulse; after release, start is required to resume.
REQ-031 First start is accepted at the first rising edge after reset deasserts.

Verification
REQ-032 Reset: hold reset 1.5 clocks, then start, pattern=8'b1011_0010, len=8, rep=1 -> w=1,0,1,1,0,0,1,0 on cycles 1-8 after the start edge; valid=1 on cycles 1-8; done=1 on cycle 9 only; busy=1 on cycles 1-9.
REQ-033 Repeat: pattern=8'b0000_0101, len=3, rep=2 -> w=1,0,1,1,0,1 over 6 contiguous valid cycles, done on cycle 7.
REQ-034 Continuous/stop: pattern=8'b0000_0010, len=2, rep=0; stop pulsed on the second bit of repetition 3 -> w=1,0,1,0,1,0, then done; no fourth repetition.
REQ-035 Boundary: len=0, pattern=8'hA5, rep=1 -> 8 bits 1,0,1,0,0,1,0,1; a start pulse during SEND changes nothing.
REQ-036 Async reset mid-SEND at bit 4 -> w, valid, busy drop to 0 immediately with no clock; done never pulses.
REQ-037 Loopback: drive w into the team's sequence detector with pattern 8'b1001_1010 -> detector z asserts at the expected bit positions.

Source files
------------

// File: rtl/bai_tap_2_sequence_generator.sv
// Serial pattern generator: sends bits [len-1:0] of a latched pattern MSB-first,
// once, a fixed number of times, or continuously until a graceful stop.
module bai_tap_2_sequence_generator #(
    parameter int WIDTH = 8,
    parameter int LW    = 4,
    parameter int RW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    input  logic [RW-1:0]    rep,
    output logic             w,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pat_q, pat_n;
    logic [IW-1:0]    last_q, last_n;
    logic [IW-1:0]    idx_q, idx_n, idx_dec, start_last;
    logic [RW-1:0]    rem_q, rem_n;
    logic             stop_q, stop_n;
    logic             w_n, valid_n, busy_n, done_n;
    logic             stop_eff, more;

    // Out-of-range length (0 or > WIDTH) falls back to the full pattern width.
    always_comb begin
        if (len == '0 || 32'(len) > 32'(WIDTH))
            start_last = IW'(WIDTH - 1);
        else
            start_last = IW'(len - LW'(1));
    end

    assign idx_dec = idx_q - IW'(1);

    always_comb begin
        state_n  = state;
        pat_n    = pat_q;
        last_n   = last_q;
        idx_n    = idx_q;
        rem_n    = rem_q;
        stop_n   = 1'b0;
        w_n      = 1'b0;
        valid_n  = 1'b0;
        busy_n   = 1'b0;
        done_n   = 1'b0;
        stop_eff = stop_q | stop;
        more     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = SEND;
                    pat_n   = pattern;
                    last_n  = start_last;
                    idx_n   = start_last;
                    rem_n   = rep;
                    w_n     = pattern[start_last];
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SEND: begin
                busy_n = 1'b1;
                // rem_q == 0 means continuous; it is never decremented in that mode.
                more   = !stop_eff && (rem_q == '0 || rem_q > RW'(1));
                if (idx_q != '0) begin
                    idx_n   = idx_dec;
                    stop_n  = stop_eff;
                    w_n     = pat_q[idx_dec];
                    valid_n = 1'b1;
                end else if (more) begin
                    idx_n   = last_q;
                    if (rem_q != '0)
                        rem_n = rem_q - RW'(1);
                    w_n     = pat_q[last_q];
                    valid_n = 1'b1;
                end else begin
                    state_n = DONE;
                    idx_n   = '0;
                    rem_n   = '0;
                    done_n  = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pat_q  <= '0;
            last_q <= '0;
            idx_q  <= '0;
            rem_q  <= '0;
            stop_q <= 1'b0;
            w      <= 1'b0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            pat_q  <= pat_n;
            last_q <= last_n;
            idx_q  <= idx_n;
            rem_q  <= rem_n;
            stop_q <= stop_n;
            w      <= w_n;
            valid  <= valid_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_bai_tap_2_sequence_generator.sv
// Directed self-checking bench for bai_tap_2_sequence_generator, including a
// "1101" detector fed by w for the loopback case.
module tb_bai_tap_2_sequence_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop;
    logic [7:0] pattern;
    logic [3:0] len, rep;
    logic       w, valid, busy, done;
    logic [2:0] det_s;
    logic       z;
    int         vectors = 0;
    int         miscompares = 0;

    bai_tap_2_sequence_generator #(.WIDTH(8), .LW(4), .RW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .pattern(pattern), .len(len), .rep(rep),
        .w(w), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Overlapping Mealy detector for "1101" on the valid bit stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      det_s <= '0;
        else if (done)  det_s <= '0;
        else if (valid) det_s <= {det_s[1:0], w};
    end
    assign z = valid && w && (det_s == 3'b110);

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Starts a transmission, scrambles the inputs after the start edge, and
    // checks {w,valid,busy,done} for each bit, the DONE cycle and the return to IDLE.
    task automatic send_check(input string tag, input logic [7:0] pat, input logic [3:0] ln,
                              input logic [3:0] rp, input logic [15:0] bits, input int n,
                              input int stop_at, input int start_at, input logic with_stop,
                              input logic chk_z, input logic [15:0] expz);
        @(negedge clk);
        start = 1'b1; stop = with_stop; pattern = pat; len = ln; rep = rp;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; pattern = ~pat; len = 4'd1; rep = 4'd3;
        for (int k = 1; k <= n; k++) begin
            chk($sformatf("%s bit%0d", tag, k), {w, valid, busy, done}, {bits[n-k], 3'b110});
            if (chk_z)
                chk($sformatf("%s z%0d", tag, k), {3'b000, z}, {3'b000, expz[n-k]});
            stop  = (k == stop_at);
            start = (k == start_at);
            @(negedge clk);
        end
        start = 1'b0;
        stop  = 1'b1;
        chk({tag, " done"}, {w, valid, busy, done}, 4'b0011);
        @(negedge clk);
        stop = 1'b0;
        chk({tag, " idle"}, {w, valid, busy, done}, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        pattern = '0; len = '0; rep = '0;
        #2;
        chk("reset", {w, valid, busy, done}, 4'b0000);
        #15 reset = 1'b0;

        send_check("single", 8'b1011_0010, 4'd8, 4'd1, 16'b1011_0010, 8, -1, -1, 1'b0, 1'b0, '0);
        // stop together with start must be ignored: both repetitions go out
        send_check("repeat", 8'b0000_0101, 4'd3, 4'd2, 16'b10_1101, 6, -1, -1, 1'b1, 1'b0, '0);
        send_check("contstop", 8'b0000_0010, 4'd2, 4'd0, 16'b10_1010, 6, 6, -1, 1'b0, 1'b0, '0);
        send_check("len0", 8'hA5, 4'd0, 4'd1, 16'b1010_0101, 8, -1, 3, 1'b0, 1'b0, '0);

        @(negedge clk);
        start = 1'b1; pattern = 8'b1011_0010; len = 4'd8; rep = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("abort bit1", {w, valid, busy, done}, 4'b1110);
        @(negedge clk);
        chk("abort bit2", {w, valid, busy, done}, 4'b0110);
        @(negedge clk);
        chk("abort bit3", {w, valid, busy, done}, 4'b1110);
        @(negedge clk);
        chk("abort bit4", {w, valid, busy, done}, 4'b1110);
        #1 reset = 1'b1;
        #1 chk("async reset", {w, valid, busy, done}, 4'b0000);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post abort", {w, valid, busy, done}, 4'b0000);
        end

        send_check("loop", 8'b1001_1010, 4'd8, 4'd1, 16'b1001_1010, 8, -1, -1, 1'b0, 1'b1, 16'b0000_0010);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
